mem_port_arbiter: RTL and testbench

Parametrised two-requester arbiter that shares one fixed-latency memory port between instruction fetch (IF) and the load/store unit (LSU), replacing the single shared grant the pipeline uses today. It adds configurable data/address width, memory latency, LSU-priority with IF anti-starvation, byte-enabled writes, per-requester response routing, and squashing of in-flight fetch responses on pipeline flush. It sits between IF_Stage/Mem_Stage and DRAM inside the core top.

---
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester (IF / LSU) arbiter sharing one fixed-latency memory port.
// LSU has priority; IF is guaranteed a grant after STARVE_LIMIT consecutive LSU wins.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                mem_en,
  input  logic                flush_ip,
  input  logic                if_req_ip,
  input  logic [ADDR_W-1:0]   if_addr_ip,
  output logic                if_gnt_op,
  output logic                if_rvalid_op,
  output logic [DATA_W-1:0]   if_rdata_op,
  input  logic                lsu_req_ip,
  input  logic                lsu_we_ip,
  input  logic [DATA_W/8-1:0] lsu_be_ip,
  input  logic [ADDR_W-1:0]   lsu_addr_ip,
  input  logic [DATA_W-1:0]   lsu_wdata_ip,
  output logic                lsu_gnt_op,
  output logic                lsu_rvalid_op,
  output logic [DATA_W-1:0]   lsu_rdata_op,
  output logic                mem_req_op,
  output logic                mem_we_op,
  output logic [DATA_W/8-1:0] mem_be_op,
  output logic [ADDR_W-1:0]   mem_addr_op,
  output logic [DATA_W-1:0]   mem_wdata_op,
  input  logic [DATA_W-1:0]   mem_rdata_ip
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY + 1) : 1;
  localparam int SW    = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_r, state_nxt;
  logic [CNT_W-1:0] lat_cnt_r;
  logic [SW-1:0]    starve_r;
  logic             owner_if_r;
  logic             owner_we_r;
  logic             squash_r;
  logic             arb;
  logic             pick_if;
  logic             done;
  logic             squash_now;

  // Arbitration, next state and the combinational grant/memory-request outputs
  always_comb begin
    state_nxt    = state_r;
    if_gnt_op    = 1'b0;
    lsu_gnt_op   = 1'b0;
    mem_req_op   = 1'b0;
    mem_we_op    = 1'b0;
    mem_be_op    = {BE_W{1'b0}};
    mem_addr_op  = {ADDR_W{1'b0}};
    mem_wdata_op = {DATA_W{1'b0}};

    arb        = reset && mem_en && (state_r == IDLE) && (if_req_ip || lsu_req_ip);
    pick_if    = if_req_ip && (!lsu_req_ip || (starve_r == SW'(STARVE_LIMIT)));
    done       = (state_r == BUSY) && (lat_cnt_r == CNT_W'(MEM_LATENCY - 1));
    squash_now = squash_r || (flush_ip && owner_if_r);

    case (state_r)
      IDLE:    if (arb) state_nxt = BUSY; else state_nxt = IDLE;
      BUSY:    if (done) state_nxt = IDLE; else state_nxt = BUSY;
      default: state_nxt = IDLE;
    endcase

    if (arb) begin
      mem_req_op = 1'b1;
      if (pick_if) begin
        if_gnt_op   = 1'b1;
        mem_be_op   = {BE_W{1'b1}};
        mem_addr_op = if_addr_ip;
      end else begin
        lsu_gnt_op   = 1'b1;
        mem_we_op    = lsu_we_ip;
        mem_be_op    = lsu_be_ip;
        mem_addr_op  = lsu_addr_ip;
        mem_wdata_op = lsu_wdata_ip;
      end
    end else begin
      mem_req_op = 1'b0;
    end
  end

  // State, latency/starve counters, ownership and the registered responses
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r       <= IDLE;
      lat_cnt_r     <= {CNT_W{1'b0}};
      starve_r      <= {SW{1'b0}};
      owner_if_r    <= 1'b0;
      owner_we_r    <= 1'b0;
      squash_r      <= 1'b0;
      if_rvalid_op  <= 1'b0;
      lsu_rvalid_op <= 1'b0;
      if_rdata_op   <= {DATA_W{1'b0}};
      lsu_rdata_op  <= {DATA_W{1'b0}};
    end else begin
      state_r       <= state_nxt;
      if_rvalid_op  <= 1'b0;
      lsu_rvalid_op <= 1'b0;
      if (arb) begin
        lat_cnt_r  <= {CNT_W{1'b0}};
        owner_if_r <= pick_if;
        owner_we_r <= !pick_if && lsu_we_ip;
        squash_r   <= pick_if && flush_ip;
        // starvation only accumulates while IF is actually waiting
        if (pick_if || !if_req_ip) begin
          starve_r <= {SW{1'b0}};
        end else if (starve_r != SW'(STARVE_LIMIT)) begin
          starve_r <= starve_r + SW'(1);
        end else begin
          starve_r <= starve_r;
        end
      end else if (state_r == BUSY) begin
        lat_cnt_r <= lat_cnt_r + CNT_W'(1);
        if (done) begin
          squash_r <= 1'b0;
          if (owner_if_r) begin
            if (!squash_now) begin
              if_rvalid_op <= 1'b1;
              if_rdata_op  <= owner_we_r ? {DATA_W{1'b0}} : mem_rdata_ip;
            end
          end else begin
            lsu_rvalid_op <= 1'b1;
            lsu_rdata_op  <= owner_we_r ? {DATA_W{1'b0}} : mem_rdata_ip;
          end
        end else begin
          squash_r <= squash_now;
        end
      end else begin
        lat_cnt_r <= lat_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed stimulus, a transaction-level
// model checked every cycle, and literal expectations from hand-worked scenarios.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LAT = 2;
  localparam int SL = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          mem_en = 1'b1;
  logic          flush_ip = 1'b0;
  logic          if_req_ip = 1'b0;
  logic [AW-1:0] if_addr_ip = '0;
  logic          if_gnt_op, if_rvalid_op;
  logic [DW-1:0] if_rdata_op;
  logic          lsu_req_ip = 1'b0;
  logic          lsu_we_ip = 1'b0;
  logic [3:0]    lsu_be_ip = 4'h0;
  logic [AW-1:0] lsu_addr_ip = '0;
  logic [DW-1:0] lsu_wdata_ip = '0;
  logic          lsu_gnt_op, lsu_rvalid_op;
  logic [DW-1:0] lsu_rdata_op;
  logic          mem_req_op, mem_we_op;
  logic [3:0]    mem_be_op;
  logic [AW-1:0] mem_addr_op;
  logic [DW-1:0] mem_wdata_op;
  logic [DW-1:0] mem_rdata_ip = '0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT), .STARVE_LIMIT(SL)) dut (
    .clock(clock), .reset(reset), .mem_en(mem_en), .flush_ip(flush_ip),
    .if_req_ip(if_req_ip), .if_addr_ip(if_addr_ip), .if_gnt_op(if_gnt_op),
    .if_rvalid_op(if_rvalid_op), .if_rdata_op(if_rdata_op),
    .lsu_req_ip(lsu_req_ip), .lsu_we_ip(lsu_we_ip), .lsu_be_ip(lsu_be_ip),
    .lsu_addr_ip(lsu_addr_ip), .lsu_wdata_ip(lsu_wdata_ip), .lsu_gnt_op(lsu_gnt_op),
    .lsu_rvalid_op(lsu_rvalid_op), .lsu_rdata_op(lsu_rdata_op),
    .mem_req_op(mem_req_op), .mem_we_op(mem_we_op), .mem_be_op(mem_be_op),
    .mem_addr_op(mem_addr_op), .mem_wdata_op(mem_wdata_op), .mem_rdata_ip(mem_rdata_ip)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct {
    int          due;
    bit          is_if;
    bit          we;
    bit          sq;
    logic [31:0] data;
  } txn_t;

  txn_t        pend[$];
  int          free_at = 0;
  int          starve = 0;
  logic [31:0] mem_m [logic [31:0]];
  logic [31:0] exp_if_rdata = '0;
  logic [31:0] exp_lsu_rdata = '0;

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return a ^ 32'h5A5A5A5A;
  endfunction

  always @(negedge clock) begin : model
    int c;
    bit e_ifrv, e_lsurv, grant, win_if;
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wdata, cur, nw;
    txn_t t;
    c = cyc;
    e_ifrv = 1'b0;
    e_lsurv = 1'b0;
    for (int i = pend.size() - 1; i >= 0; i--) begin
      if (pend[i].due == c) begin
        if (!pend[i].sq) begin
          if (pend[i].is_if) begin e_ifrv = 1'b1; exp_if_rdata = pend[i].data; end
          else begin e_lsurv = 1'b1; exp_lsu_rdata = pend[i].data; end
        end
        pend.delete(i);
      end
    end
    grant  = reset && mem_en && (c >= free_at) && (if_req_ip || lsu_req_ip);
    win_if = if_req_ip && (!lsu_req_ip || starve == SL);
    e_we = 1'b0; e_be = 4'h0; e_addr = 32'h0; e_wdata = 32'h0;
    if (grant && win_if) begin
      e_be = 4'hF; e_addr = if_addr_ip;
    end else if (grant) begin
      e_we = lsu_we_ip; e_be = lsu_be_ip; e_addr = lsu_addr_ip; e_wdata = lsu_wdata_ip;
    end
    chk("if_gnt", if_gnt_op, grant && win_if);
    chk("lsu_gnt", lsu_gnt_op, grant && !win_if);
    chk("mem_req", mem_req_op, grant);
    chk("mem_we", mem_we_op, e_we);
    chk("mem_be", mem_be_op, e_be);
    chk("mem_addr", mem_addr_op, e_addr);
    chk("mem_wdata", mem_wdata_op, e_wdata);
    chk("if_rvalid", if_rvalid_op, e_ifrv);
    chk("lsu_rvalid", lsu_rvalid_op, e_lsurv);
    chk("if_rdata", if_rdata_op, exp_if_rdata);
    chk("lsu_rdata", lsu_rdata_op, exp_lsu_rdata);
    if (!reset) begin
      pend.delete();
      free_at = c + 1;
      starve = 0;
      exp_if_rdata = '0;
      exp_lsu_rdata = '0;
    end else begin
      if (grant) begin
        t.due = c + LAT + 1;
        t.is_if = win_if;
        t.we = !win_if && lsu_we_ip;
        t.sq = 1'b0;
        t.data = win_if ? rd(if_addr_ip) : (lsu_we_ip ? 32'h0 : rd(lsu_addr_ip));
        if (t.we) begin
          cur = rd(lsu_addr_ip);
          for (int b = 0; b < 4; b++)
            nw[b*8 +: 8] = lsu_be_ip[b] ? lsu_wdata_ip[b*8 +: 8] : cur[b*8 +: 8];
          mem_m[lsu_addr_ip] = nw;
        end
        pend.push_back(t);
        free_at = c + LAT + 1;
        if (win_if || !if_req_ip) starve = 0;
        else if (starve < SL) starve = starve + 1;
      end
      if (flush_ip)
        foreach (pend[i]) if (pend[i].is_if && pend[i].due > c) pend[i].sq = 1'b1;
    end
    mem_rdata_ip = 32'hBAD00000 ^ c;
    foreach (pend[i])
      if (pend[i].due == c + 1) mem_rdata_ip = pend[i].we ? 32'hC0FFEE00 : pend[i].data;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clock);
  endtask

  task automatic issue_if(input logic [31:0] a, output int t);
    if_req_ip = 1'b1;
    if_addr_ip = a;
    t = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clock);
      if (if_gnt_op === 1'b1) begin t = cyc; break; end
    end
    if (t < 0) chk("if_gnt_timeout", 64'd0, 64'd1);
    else chk("if_grant_addr", mem_addr_op, a);
    @(posedge clock); #1;
    if_req_ip = 1'b0;
  endtask

  task automatic issue_lsu(input logic we, input logic [3:0] be, input logic [31:0] a,
                           input logic [31:0] d, output int t);
    lsu_req_ip = 1'b1; lsu_we_ip = we; lsu_be_ip = be; lsu_addr_ip = a; lsu_wdata_ip = d;
    t = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clock);
      if (lsu_gnt_op === 1'b1) begin t = cyc; break; end
    end
    if (t < 0) chk("lsu_gnt_timeout", 64'd0, 64'd1);
    else begin
      chk("lsu_grant_we", mem_we_op, we);
      chk("lsu_grant_be", mem_be_op, be);
    end
    @(posedge clock); #1;
    lsu_req_ip = 1'b0;
  endtask

  task automatic summary;
    $display("%0d/%0d checks passed", passes, checks);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    summary();
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin : stim
    int t, t_if, t_l, n_before, t_en;
    int lg[$];
    mem_m[32'h10] = 32'hDEADBEEF;
    if_req_ip = 1'b1;
    lsu_req_ip = 1'b1;
    step(2);
    @(negedge clock);
    chk("rst_mem_req", mem_req_op, 1'b0);
    chk("rst_if_rvalid", if_rvalid_op, 1'b0);
    chk("rst_lsu_rdata", lsu_rdata_op, 32'h0);
    step(1);
    if_req_ip = 1'b0;
    lsu_req_ip = 1'b0;
    reset = 1'b1;
    step(1);

    // single fetch
    issue_if(32'h10, t);
    wait_cyc(t + 3);
    chk("t1_if_rvalid", if_rvalid_op, 1'b1);
    chk("t1_if_rdata", if_rdata_op, 32'hDEADBEEF);
    wait_cyc(t + 4);
    chk("t1_pulse_end", if_rvalid_op, 1'b0);
    step(1);

    // simultaneous IF + LSU load
    fork
      issue_if(32'h20, t_if);
      issue_lsu(1'b0, 4'hF, 32'h40, 32'h0, t_l);
    join
    chk("t2_if_after_lsu", 64'(t_if - t_l), 64'd3);
    chk("t2_lsu_rdata", lsu_rdata_op, 32'h5A5A5A1A);
    wait_cyc(t_if + 3);
    chk("t2_if_rvalid", if_rvalid_op, 1'b1);
    chk("t2_if_rdata", if_rdata_op, 32'h5A5A5A7A);
    step(1);

    // byte-enabled store then read-back
    issue_lsu(1'b1, 4'b0011, 32'h80, 32'h1234ABCD, t);
    wait_cyc(t + 3);
    chk("t3_store_ack", lsu_rvalid_op, 1'b1);
    chk("t3_store_rdata", lsu_rdata_op, 32'h0);
    step(1);
    issue_lsu(1'b0, 4'hF, 32'h80, 32'h0, t);
    wait_cyc(t + 3);
    chk("t3_readback", lsu_rdata_op, 32'h5A5AABCD);
    step(1);

    // IF anti-starvation
    fork
      issue_if(32'h30, t_if);
      for (int k = 0; k < 6; k++) begin
        issue_lsu(1'b0, 4'hF, 32'h100 + 32'(4 * k), 32'h0, t_l);
        lg.push_back(t_l);
      end
    join
    n_before = 0;
    foreach (lg[i]) if (lg[i] < t_if) n_before++;
    chk("t4_lsu_before_if", 64'(n_before), 64'd4);
    if (lg.size() == 6) chk("t4_lsu_resumes", 64'(lg[4] - t_if), 64'd3);
    else chk("t4_lsu_count", 64'(lg.size()), 64'd6);
    step(2);

    // flush squashes IF, not LSU, and not an rvalid already issuing
    issue_if(32'h44, t);
    flush_ip = 1'b1;
    step(1);
    flush_ip = 1'b0;
    wait_cyc(t + 3);
    chk("t5_squashed", if_rvalid_op, 1'b0);
    step(1);
    issue_if(32'h48, t);
    wait_cyc(t + 3);
    chk("t5_next_if_rvalid", if_rvalid_op, 1'b1);
    chk("t5_next_if_rdata", if_rdata_op, 32'h5A5A5A12);
    step(1);
    issue_lsu(1'b0, 4'hF, 32'h60, 32'h0, t);
    flush_ip = 1'b1;
    step(1);
    flush_ip = 1'b0;
    wait_cyc(t + 3);
    chk("t5_lsu_unaffected", lsu_rvalid_op, 1'b1);
    step(1);
    issue_if(32'h4C, t);
    step(2);
    flush_ip = 1'b1;
    @(negedge clock);
    chk("t5_flush_in_rvalid", if_rvalid_op, 1'b1);
    step(1);
    flush_ip = 1'b0;
    step(1);

    // reset mid-transaction
    issue_if(32'h50, t);
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    wait_cyc(t + 3);
    chk("t6_rst_no_rvalid", if_rvalid_op, 1'b0);
    chk("t6_rst_rdata", if_rdata_op, 32'h0);
    step(1);

    // mem_en low: in-flight completes, no new grants
    issue_lsu(1'b0, 4'hF, 32'h70, 32'h0, t);
    mem_en = 1'b0;
    wait_cyc(t + 3);
    chk("t6_inflight_done", lsu_rvalid_op, 1'b1);
    step(1);
    if_req_ip = 1'b1; if_addr_ip = 32'h54;
    lsu_req_ip = 1'b1; lsu_we_ip = 1'b0; lsu_be_ip = 4'hF; lsu_addr_ip = 32'h74;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("t6_blocked", {if_gnt_op, lsu_gnt_op, mem_req_op}, 3'b000);
      step(1);
    end
    mem_en = 1'b1;
    @(negedge clock);
    t_en = cyc;
    chk("t6_resume_lsu", lsu_gnt_op, 1'b1);
    step(1);
    lsu_req_ip = 1'b0;
    issue_if(32'h54, t);
    chk("t6_if_after", 64'(t - t_en), 64'd3);
    wait_cyc(t + 4);
    step(3);
    summary();
    $finish;
  end

endmodule
